row_stream_arbiter: RTL and testbench

//  Merges the encoded-word streams of NUM_ROWS row encoders into one 32-bit output stream.
//  The row encoders push words as single-cycle data_ready pulses and cannot be stalled.

---
 rtl/row_arb_pkg.sv | 36 +++
 rtl/row_fifo.sv | 55 +++++
 rtl/row_stream_arbiter.sv | 121 ++++++++++++
 tb/tb_row_stream_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_arb_pkg.sv
// Shared constants and helpers for the row stream arbiter.
// Provides the encoded-word prefixes, the alarm word, and rr_pick(), which returns the
// round-robin grant index for a request vector.
package row_arb_pkg;

    localparam int unsigned WORD_W = 32;

    // Two-bit prefixes carried in the top bits of encoded words (forwarded untouched).
    localparam logic [1:0] PFX_DATA  = 2'b00;
    localparam logic [1:0] PFX_TIME  = 2'b01;
    localparam logic [1:0] PFX_ALARM = 2'b10;

    localparam logic [WORD_W-1:0] ALARM_WORD = 32'h8000_0000;

    // Widest request vector rr_pick() accepts; callers zero-extend to this width.
    localparam int unsigned RR_MAX = 32;

    // First set bit of req searched from (last+1) mod nrows upward. Returns last if none set.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned       last,
                                            input int unsigned       nrows);
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = last + k;
            if (idx >= nrows) idx = idx - nrows;
            if ((k <= nrows) && !found && req[idx[4:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/row_fifo.sv
// Single-row word FIFO, DEPTH x W.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop (read),
//        rd_data_c (combinational head word), full_c, empty_c (combinational status).
// Push and pop in the same cycle are allowed, including when full; the caller must not
// push when full unless it also pops, and must not pop when empty.
module row_fifo
    import row_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rd_data_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign rd_data_c = mem[rd_ptr];
    assign full_c    = (count == (AW+1)'(DEPTH));
    assign empty_c   = (count == '0);

    // Storage array; contents are don't-care after reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/row_stream_arbiter.sv
// Merges NUM_ROWS non-stallable row-encoder word streams into one valid/ready stream.
// Each row feeds a row_fifo; a round-robin scheduler drains them into a registered output
// tagged with the source row.
// Ports: clk, rst_n (async active-low); row_data/row_ready (per-row write pulses);
//        out_data/out_row/out_valid/out_ready (merged output); ovf (sticky per-row
//        overflow), ovf_clr (sync clear of ovf).
// Optional: macro DROP_CNT_EN adds drop_cnt[15:0], a saturating count of dropped words.
module row_stream_arbiter
    import row_arb_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned ROW_W   = $clog2(NUM_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_W*NUM_ROWS-1:0] row_data,
    input  logic [NUM_ROWS-1:0]        row_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic [ROW_W-1:0]           out_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_ROWS-1:0]        ovf,
`ifdef DROP_CNT_EN
    output logic [15:0]                drop_cnt,
`endif
    input  logic                       ovf_clr
);

    logic [NUM_ROWS-1:0] empty;
    logic [NUM_ROWS-1:0] full;
    logic [NUM_ROWS-1:0] push;
    logic [NUM_ROWS-1:0] pop;
    logic [NUM_ROWS-1:0] drop;
    logic [WORD_W-1:0]   head [NUM_ROWS];

    logic [ROW_W-1:0]    last_grant;
    logic [ROW_W-1:0]    grant_idx;
    logic                load;
    logic                any_req;

    // Grant selection and per-row push/pop/drop decode.
    always_comb begin
        pop       = '0;
        push      = '0;
        drop      = '0;
        load      = !out_valid || out_ready;
        any_req   = |(~empty);
        grant_idx = ROW_W'(rr_pick(RR_MAX'(~empty), 32'(last_grant), NUM_ROWS));
        if (load && any_req) pop[grant_idx] = 1'b1;
        // A full FIFO still accepts a word if it is popped in the same cycle.
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            push[i] = row_ready[i] && (!full[i] || pop[i]);
            drop[i] = row_ready[i] && full[i] && !pop[i];
        end
    end

    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_fifo
        row_fifo #(
            .DEPTH (DEPTH),
            .W     (WORD_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .wdata     (row_data[WORD_W*g +: WORD_W]),
            .pop       (pop[g]),
            .rd_data_c (head[g]),
            .full_c    (full[g]),
            .empty_c   (empty[g])
        );
    end

    // Output register, RR pointer and sticky overflow flags.
    // last_grant resets to the top row so the first search starts at row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_row    <= '0;
            out_valid  <= 1'b0;
            ovf        <= '0;
            last_grant <= ROW_W'(NUM_ROWS - 1);
        end else begin
            if (load) begin
                if (any_req) begin
                    out_data   <= head[grant_idx];
                    out_row    <= grant_idx;
                    out_valid  <= 1'b1;
                    last_grant <= grant_idx;
                end else begin
                    out_valid  <= 1'b0;
                end
            end
            // A new overflow wins over a same-edge clear.
            ovf <= (ovf & ~{NUM_ROWS{ovf_clr}}) | drop;
        end
    end

`ifdef DROP_CNT_EN
    logic [15:0] n_drop;
    logic [16:0] cnt_sum;

    // Clear applies first, then this cycle's drops are added with saturation.
    always_comb begin
        n_drop = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            n_drop = n_drop + 16'(drop[i]);
        end
        cnt_sum = 17'(ovf_clr ? 16'd0 : drop_cnt) + 17'(n_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_row_stream_arbiter.sv
// Bench for row_stream_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on the accepted output sequence.
module tb_row_stream_arbiter;
    import row_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned RW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [32*N-1:0]   row_data;
    logic [N-1:0]      row_ready;
    logic [31:0]       out_data;
    logic [RW-1:0]     out_row;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      ovf;
    logic              ovf_clr;
`ifdef DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    row_stream_arbiter #(.NUM_ROWS(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_data  (row_data),
        .row_ready (row_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
`ifdef DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model: per-row queues + output slot ----------------
    logic [31:0] mq [N][$];
    int          m_last;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_row;
    logic [N-1:0] m_ovf;
    int          m_drops;

    initial begin : model
        int   r;
        logic found;
        int   nd;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) mq[i].delete();
                m_last  = N - 1;
                m_valid = 1'b0;
                m_data  = '0;
                m_row   = 0;
                m_ovf   = '0;
                m_drops = 0;
            end else begin
                // Output slot frees up: take the next non-empty row after the last grant.
                if (!m_valid || out_ready) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        r = (m_last + k) % N;
                        if (!found && mq[r].size() > 0) begin
                            found  = 1'b1;
                            m_data = mq[r].pop_front();
                            m_row  = r;
                            m_last = r;
                        end
                    end
                    m_valid = found;
                end
                // Writes see the queue after this cycle's pop.
                if (ovf_clr) begin
                    m_ovf   = '0;
                    m_drops = 0;
                end
                nd = 0;
                for (int i = 0; i < N; i++) begin
                    if (row_ready[i]) begin
                        if (mq[i].size() < D) mq[i].push_back(row_data[32*i +: 32]);
                        else begin
                            nd++;
                            m_ovf[i] = 1'b1;
                        end
                    end
                end
                m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
            end
        end
    end

    // ---------------- per-cycle compare and accepted-word monitor ----------------
    logic [31:0] got_d [$];
    int          got_r [$];

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("out_data",  out_data, m_data);
                chk("out_row",   32'(out_row), 32'(m_row));
                chk("ovf",       32'(ovf), 32'(m_ovf));
`ifdef DROP_CNT_EN
                chk("drop_cnt",  32'(drop_cnt), 32'(m_drops));
`endif
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data);
                    got_r.push_back(int'(out_row));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        row_ready = '0;
        ovf_clr   = 1'b0;
        tick();
        rst_n = 1'b1;
        got_d.delete();
        got_r.delete();
    endtask

    task automatic chk_seq(input string nm, input int k, input logic [31:0] ed, input int er);
        chk({nm, "_data"}, (k < got_d.size()) ? got_d[k] : 32'hDEAD_DEAD, ed);
        chk({nm, "_row"},  (k < got_r.size()) ? 32'(got_r[k]) : 32'hDEAD_DEAD, 32'(er));
    endtask

    task automatic push_row1_six(input logic clr_on_last);
        for (int j = 0; j < 6; j++) begin
            row_data[32*1 +: 32] = 32'h0000_0100 + 32'(j);
            row_ready = 4'b0010;
            ovf_clr   = clr_on_last && (j == 5);
            tick();
        end
        row_ready = '0;
        ovf_clr   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        row_data  = '0;
        row_ready = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_row",   32'(out_row), 32'd0);
        chk("rst_ovf",       32'(ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single word from row 2, visible two edges after its write.
        row_data[32*2 +: 32] = 32'h0000_1234;
        row_ready = 4'b0100;
        tick();
        row_ready = '0;
        @(negedge clk);
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  out_data, 32'h0000_1234);
        chk("t1_row",   32'(out_row), 32'd2);
        @(negedge clk);
        chk("t1_gone",  32'(out_valid), 32'd0);
        tick();

        // 2: simultaneous alarm from every row.
        do_reset();
        for (int i = 0; i < N; i++) row_data[32*i +: 32] = ALARM_WORD;
        row_ready = 4'b1111;
        tick();
        row_ready = '0;
        repeat (8) tick();
        chk("t2_count", 32'(got_d.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_seq("t2", k, ALARM_WORD, k);
        chk("t2_ovf", 32'(ovf), 32'd0);

        // 3: rows 0 and 3 interleave in round-robin order.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            row_data[32*0 +: 32] = 32'hA000_0000 + 32'(j);
            row_data[32*3 +: 32] = 32'hB000_0000 + 32'(j);
            row_ready = 4'b1001;
            tick();
        end
        row_ready = '0;
        repeat (10) tick();
        chk("t3_count", 32'(got_d.size()), 32'd6);
        for (int j = 0; j < 3; j++) begin
            chk_seq("t3", 2*j,     32'hA000_0000 + 32'(j), 0);
            chk_seq("t3", 2*j + 1, 32'hB000_0000 + 32'(j), 3);
        end

        // 4: backpressure, row 1 overflows on its sixth word.
        do_reset();
        out_ready = 1'b0;
        push_row1_six(1'b0);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_head",  out_data, 32'h0000_0100);
        chk("t4_ovf",   32'(ovf), 32'b0010);
`ifdef DROP_CNT_EN
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        repeat (3) tick();
        chk("t4_stable", out_data, 32'h0000_0100);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("t4_count", 32'(got_d.size()), 32'd5);
        for (int j = 0; j < 5; j++) chk_seq("t4", j, 32'h0000_0100 + 32'(j), 1);

        // 5: clear with no overflow, then clear colliding with a drop.
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_clr_ovf", 32'(ovf), 32'd0);
`ifdef DROP_CNT_EN
        chk("t5_clr_cnt", 32'(drop_cnt), 32'd0);
`endif
        out_ready = 1'b0;
        push_row1_six(1'b1);
        chk("t5_set_wins", 32'(ovf), 32'b0010);
`ifdef DROP_CNT_EN
        chk("t5_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        out_ready = 1'b1;
        repeat (8) tick();

        // 6: reset while three words are queued behind a held output.
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            row_data[32*0 +: 32] = 32'hC000_0000 + 32'(j);
            row_ready = 4'b0001;
            tick();
        end
        row_ready = '0;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_data",  out_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        got_d.delete();
        got_r.delete();
        repeat (10) tick();
        chk("t6_no_stale", 32'(got_d.size()), 32'd0);

        // Mixed traffic with intermittent backpressure, checked by the model.
        do_reset();
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++)
                row_data[32*i +: 32] = {(c % 3 == 0) ? PFX_TIME : PFX_DATA, 6'(i), 24'(c)};
            row_ready = 4'((c * 5) ^ (c >> 1));
            out_ready = (c % 3) != 0 || c > 60;
            ovf_clr   = (c == 30);
            tick();
        end
        row_ready = '0;
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
